subset_scan_ctrl: RTL and testbench
===================================

Name: subset_scan_ctrl

Overview:
Scan controller for a single shared Subset circle-membership datapath. It latches one configuration (centres, squared radii, mode) and steps the Subset position inputs through every point of the 2^COORD_W x 2^COORD_W grid, one point per cycle. It collects the activated result into per-row bitmasks, streams each row out over a valid/ready handshake, and reports the total activated-point count. It sits between the system controller, which issues start and sinks rows, and one Subset instance.

Parameters:
COORD_W, 4, coordinate width; grid side N = 2^COORD_W; must match Subset position width (4)
CNT_W, 2*COORD_W+1, width of active_count; holds 0..N*N

Ports:
clk  in  1  system clock
rst  in  1  reset
start  in  1  begin scan; sampled only in IDLE
central_in  in  24  centre coordinates, Subset packing
radius_square_in  in  24  squared radii, Subset packing
mode_in  in  2  Subset mode
central  out  24  latched centres, to Subset
radius_square  out  24  latched radii, to Subset
mode  out  2  latched mode, to Subset
pos_x  out  COORD_W  scan x, to Subset position_x
pos_y  out  COORD_W  scan y, to Subset position_y
activated  in  1  Subset result for (pos_x, pos_y), combinational same cycle
busy  out  1  high in any state except IDLE
row_valid  out  1  row_mask/row_y valid
row_ready  in  1  sink accepts row
row_y  out  COORD_W  row index of row_mask
row_mask  out  N  bit i = activated at x=i in row row_y
done  out  1  one-cycle pulse, scan complete
active_count  out  CNT_W  activated-point total of last scan

Behaviour:
- One clock: clk. Reset is synchronous and active-high (rst). rst has priority over every other input in every state.
- Reset values:
  - state IDLE
  - pos_x = pos_y = 0, row_y = 0
  - central = radius_square = 0, mode = 0
  - row_valid = 0, row_mask = 0, done = 0, busy = 0, active_count = 0
- rst asserted mid-scan: abort and return to IDLE next cycle. No done pulse. No further rows are emitted.
- IDLE:
  - start=1 latches central_in/radius_square_in/mode_in, clears active_count and row_mask, sets pos = (0,0), goes to SCAN.
  - Config inputs are ignored after this cycle.
- SCAN:
  - Each cycle samples activated into row_mask[pos_x].
  - If activated=1, active_count increments (no saturation; max N*N fits CNT_W).
  - If pos_x < N-1, pos_x increments.
  - If pos_x = N-1, go to ROW_OUT with row_valid=1 and row_y=pos_y. The mask presented includes the final sample.
- ROW_OUT:
  - row_valid, row_y and row_mask are held stable until row_ready=1. The scan is stalled meanwhile.
  - On accept (row_valid & row_ready):
    - pos_y < N-1: pos_y increments, pos_x=0, row_mask cleared, row_valid=0 next cycle, back to SCAN.
    - pos_y = N-1: go to DONE.
  - row_ready while row_valid=0 has no effect.
- DONE:
  - done=1 for exactly this cycle; active_count is final. Go to IDLE.
  - active_count holds until the next accepted start.
- start outside IDLE is ignored. A start asserted in the DONE cycle is ignored; start must be re-asserted in IDLE.
- Latency with row_ready tied high: start in cycle t → 17 cycles per row → last accept at t+272 → done=1 at t+273.
- pos_x/pos_y are registered. Subset is purely combinational, so activated is consumed in the same cycle the position is presented.

Optional Feature:
SUBSET_SCAN_ABORT_EN
- Defined: adds an input port abort (1 bit). abort=1 in SCAN or ROW_OUT returns to IDLE next cycle.
  - row_valid drops immediately, no done pulse.
  - active_count keeps the partial count.
  - abort in IDLE or DONE is ignored.
  - rst still has priority.
- Undefined: no abort port; a scan always runs to completion unless rst is asserted.

Test Plan:
1. Mode 0, A centre (0,0), r²=4, row_ready=1 → rows 0/1/2 masks 0x0007/0x0003/0x0001, all other rows 0x0000. active_count=6. done pulses at t+273.
2. Mode 1, A (0,0) r²=4, B (15,15) r²=4 → every row_mask 0x0000, active_count=0, done asserted once.
3. Mode 2, A (0,0) r²=1, B (1,0) r²=0 → row 0 mask 0x0001, row 1 mask 0x0001, active_count=2.
4. Backpressure: case 1 with row_ready low for 5 cycles on every row → row_valid/row_y/row_mask stable while stalled. pos_x/pos_y unchanged during the stall. Same masks and count. done at t+273+80.
5. Start/config robustness: start held high through the whole scan, and central_in/mode_in changed mid-scan → a single scan runs, results match the latched config, no restart.
6. rst asserted after row 3 is accepted → next cycle busy=0, row_valid=0, active_count=0, no done. A new start then yields the full correct result.

Source files
------------

// File: rtl/subset_scan_ctrl.sv
// subset_scan_ctrl
// Walks a single shared Subset circle-membership datapath over every point
// of the 2^COORD_W x 2^COORD_W grid, one point per cycle. It gathers each
// row of results into a bitmask, hands the row to a sink over valid/ready,
// and keeps a running total of activated points.
//
// Build option: define SUBSET_SCAN_ABORT_EN to add an 'abort' input that
// cancels a scan in progress. The partial activated count is kept. Without
// the macro, a scan always runs to completion unless rst is asserted.
module subset_scan_ctrl #(
  parameter int COORD_W = 4,
  parameter int CNT_W   = 2*COORD_W+1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
`ifdef SUBSET_SCAN_ABORT_EN
  input  logic                    abort,
`endif
  input  logic [23:0]             central_in,
  input  logic [23:0]             radius_square_in,
  input  logic [1:0]              mode_in,
  output logic [23:0]             central,
  output logic [23:0]             radius_square,
  output logic [1:0]              mode,
  output logic [COORD_W-1:0]      pos_x,
  output logic [COORD_W-1:0]      pos_y,
  input  logic                    activated,
  output logic                    busy,
  output logic                    row_valid,
  input  logic                    row_ready,
  output logic [COORD_W-1:0]      row_y,
  output logic [(1<<COORD_W)-1:0] row_mask,
  output logic                    done,
  output logic [CNT_W-1:0]        active_count
);

  // The last coordinate on either axis (N-1). Reaching it on x ends a row,
  // and reaching it on y ends the scan.
  localparam logic [COORD_W-1:0] POS_LAST = '1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    ROW_OUT,
    DONE
  } state_t;

  state_t state;

  // The sink takes the presented row on the edge where both sides agree.
  logic row_accept;
  assign row_accept = row_valid & row_ready;

`ifdef SUBSET_SCAN_ABORT_EN
  // An abort only matters while a scan is in flight. In IDLE and DONE it is
  // simply ignored.
  logic abort_hit;
  assign abort_hit = abort & ((state == SCAN) | (state == ROW_OUT));
`endif

  // Scan sequencer. All outputs are registered here. The position drives
  // Subset directly, and 'activated' comes back in the same cycle, so the
  // sample for (pos_x, pos_y) is captured on the edge that advances pos_x.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      pos_x         <= '0;
      pos_y         <= '0;
      row_y         <= '0;
      central       <= '0;
      radius_square <= '0;
      mode          <= '0;
      row_valid     <= 1'b0;
      row_mask      <= '0;
      done          <= 1'b0;
      busy          <= 1'b0;
      active_count  <= '0;
    end
`ifdef SUBSET_SCAN_ABORT_EN
    else if (abort_hit) begin
      state     <= IDLE;
      busy      <= 1'b0;
      row_valid <= 1'b0;
      done      <= 1'b0;
    end
`endif
    else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            central       <= central_in;
            radius_square <= radius_square_in;
            mode          <= mode_in;
            active_count  <= '0;
            row_mask      <= '0;
            pos_x         <= '0;
            pos_y         <= '0;
            busy          <= 1'b1;
            state         <= SCAN;
          end
        end

        SCAN: begin
          row_mask[pos_x] <= activated;
          if (activated) begin
            active_count <= active_count + CNT_W'(1);
          end
          if (pos_x == POS_LAST) begin
            row_valid <= 1'b1;
            row_y     <= pos_y;
            state     <= ROW_OUT;
          end else begin
            pos_x <= pos_x + COORD_W'(1);
          end
        end

        ROW_OUT: begin
          if (row_accept) begin
            row_valid <= 1'b0;
            if (pos_y == POS_LAST) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              pos_y    <= pos_y + COORD_W'(1);
              pos_x    <= '0;
              row_mask <= '0;
              state    <= SCAN;
            end
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy      <= 1'b0;
          row_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_subset_scan_ctrl.sv
// tb_subset_scan_ctrl
// Directed bench for subset_scan_ctrl. A small behavioural stand-in for
// Subset answers 'activated' from the controller's latched config and scan
// position. Expected rows are queued before each scan and popped as the
// sink accepts them.
module tb_subset_scan_ctrl;

  localparam int COORD_W = 4;
  localparam int N       = 16;
  localparam int CNT_W   = 9;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [23:0]        central_in;
  logic [23:0]        radius_square_in;
  logic [1:0]         mode_in;
  logic [23:0]        central;
  logic [23:0]        radius_square;
  logic [1:0]         mode;
  logic [COORD_W-1:0] pos_x;
  logic [COORD_W-1:0] pos_y;
  logic               activated;
  logic               busy;
  logic               row_valid;
  logic               row_ready;
  logic [COORD_W-1:0] row_y;
  logic [N-1:0]       row_mask;
  logic               done;
  logic [CNT_W-1:0]   active_count;
`ifdef SUBSET_SCAN_ABORT_EN
  logic               abort;
`endif

  typedef struct packed {
    logic [3:0]  y;
    logic [15:0] mask;
  } row_t;

  row_t expQ[$];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [23:0] expC;
  logic [23:0] expR;
  logic [1:0]  expM;

  logic inA;
  logic inB;
  logic inC;

  subset_scan_ctrl #(.COORD_W(COORD_W), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
`ifdef SUBSET_SCAN_ABORT_EN
    .abort            (abort),
`endif
    .central_in       (central_in),
    .radius_square_in (radius_square_in),
    .mode_in          (mode_in),
    .central          (central),
    .radius_square    (radius_square),
    .mode             (mode),
    .pos_x            (pos_x),
    .pos_y            (pos_y),
    .activated        (activated),
    .busy             (busy),
    .row_valid        (row_valid),
    .row_ready        (row_ready),
    .row_y            (row_y),
    .row_mask         (row_mask),
    .done             (done),
    .active_count     (active_count)
  );

  // Free-running clock and a cycle counter used for latency checks.
  always #5 clk = ~clk;

  // Counts rising edges. Latency is measured as the difference between two
  // samples of this counter.
  always @(posedge clk) cyc <= cyc + 1;

  // Point-in-circle test with an inclusive boundary: dx^2 + dy^2 <= r^2.
  function automatic logic inCircle(input logic [3:0] cx, input logic [3:0] cy,
                                    input logic [3:0] px, input logic [3:0] py,
                                    input logic [7:0] r2);
    int dx;
    int dy;
    dx = int'(px) - int'(cx);
    dy = int'(py) - int'(cy);
    return (dx*dx + dy*dy) <= int'(r2);
  endfunction

  // Behavioural Subset stand-in. Circle A uses bits [7:0] of centre and
  // radius, B uses [15:8], and C uses [23:16]. Each centre field is packed
  // as {y, x}. Mode 0 = A, 1 = A and B, 2 = A and not B, 3 = A, B and C.
  always_comb begin
    inA = inCircle(central[3:0],   central[7:4],   pos_x, pos_y, radius_square[7:0]);
    inB = inCircle(central[11:8],  central[15:12], pos_x, pos_y, radius_square[15:8]);
    inC = inCircle(central[19:16], central[23:20], pos_x, pos_y, radius_square[23:16]);
    case (mode)
      2'd0:    activated = inA;
      2'd1:    activated = inA & inB;
      2'd2:    activated = inA & ~inB;
      default: activated = inA & inB & inC;
    endcase
  end

  function automatic logic [23:0] packC(input logic [3:0] ax, input logic [3:0] ay,
                                        input logic [3:0] bx, input logic [3:0] by);
    return {8'h00, by, bx, ay, ax};
  endfunction

  function automatic logic [23:0] packR(input logic [7:0] ra, input logic [7:0] rb);
    return {8'h00, rb, ra};
  endfunction

  // One comparison: counts it, and on a miss counts and reports it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drives a configuration and remembers it as the value the DUT must latch.
  task automatic applyStimulus(input logic [23:0] c, input logic [23:0] r,
                               input logic [1:0] m);
    central_in       = c;
    radius_square_in = r;
    mode_in          = m;
    expC             = c;
    expR             = r;
    expM             = m;
  endtask

  // Queues the expected rows. Only rows 0..2 can be non-zero for these
  // small circles near the origin.
  task automatic pushRows(input logic [15:0] m0, input logic [15:0] m1,
                          input logic [15:0] m2);
    row_t r;
    expQ.delete();
    for (int i = 0; i < N; i++) begin
      r.y    = 4'(i);
      r.mask = (i == 0) ? m0 : (i == 1) ? m1 : (i == 2) ? m2 : 16'h0000;
      expQ.push_back(r);
    end
  endtask

  // Runs one scan from the current falling edge. It can stall each row by
  // 'stall' cycles, hold start high, churn the config inputs, or assert rst
  // right after row 'rstAfterRow' is accepted (-1 = never).
  task automatic runScan(input string tag, input int stall, input bit holdStart,
                         input bit churn, input int rstAfterRow,
                         input int expOffset, input int expCount);
    int   startCyc;
    int   rowsSeen;
    int   waitCnt;
    int   budget;
    bit   finished;
    bit   resetPending;
    row_t head;
    startCyc     = cyc;
    rowsSeen     = 0;
    waitCnt      = 0;
    budget       = 0;
    finished     = 1'b0;
    resetPending = 1'b0;
    start        = 1'b1;
    row_ready    = 1'b1;
    while (!finished && budget < 1000) begin
      @(negedge clk);
      budget++;
      if (!holdStart) start = 1'b0;
      if (resetPending) begin
        rst = 1'b1;
        @(negedge clk);
        checkOutput({tag, " busy after rst"}, busy, 0);
        checkOutput({tag, " row_valid after rst"}, row_valid, 0);
        checkOutput({tag, " count after rst"}, active_count, 0);
        checkOutput({tag, " done after rst"}, done, 0);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          checkOutput({tag, " no done after rst"}, done, 0);
          checkOutput({tag, " no row after rst"}, row_valid, 0);
        end
        expQ.delete();
        finished = 1'b1;
      end else begin
        if (budget == 1) begin
          checkOutput({tag, " busy after start"}, busy, 1);
          checkOutput({tag, " pos_x start"}, pos_x, 0);
          checkOutput({tag, " pos_y start"}, pos_y, 0);
          checkOutput({tag, " count cleared"}, active_count, 0);
          checkOutput({tag, " central latched"}, central, expC);
          checkOutput({tag, " radius latched"}, radius_square, expR);
          checkOutput({tag, " mode latched"}, mode, expM);
        end
        if (churn) begin
          central_in       = 24'($urandom);
          radius_square_in = 24'($urandom);
          mode_in          = 2'($urandom);
        end
        if (done) begin
          checkOutput({tag, " done latency"}, cyc - startCyc, expOffset);
          checkOutput({tag, " active_count"}, active_count, expCount);
          checkOutput({tag, " rows accepted"}, rowsSeen, N);
          checkOutput({tag, " rows left"}, expQ.size(), 0);
          checkOutput({tag, " row_valid in done"}, row_valid, 0);
          checkOutput({tag, " busy in done"}, busy, 1);
          checkOutput({tag, " central held"}, central, expC);
          checkOutput({tag, " mode held"}, mode, expM);
          finished = 1'b1;
        end else if (row_valid) begin
          if (expQ.size() == 0) begin
            checkOutput({tag, " row with empty queue"}, expQ.size(), 1);
            row_ready = 1'b1;
          end else begin
            head = expQ[0];
            checkOutput({tag, " row_y"}, row_y, head.y);
            checkOutput({tag, " row_mask"}, row_mask, head.mask);
            checkOutput({tag, " pos_y in row_out"}, pos_y, head.y);
            checkOutput({tag, " pos_x in row_out"}, pos_x, N-1);
            if (waitCnt < stall) begin
              row_ready = 1'b0;
              waitCnt++;
            end else begin
              row_ready = 1'b1;
              void'(expQ.pop_front());
              rowsSeen++;
              waitCnt = 0;
              if (rowsSeen == rstAfterRow + 1) resetPending = 1'b1;
            end
          end
        end else begin
          row_ready = 1'b1;
        end
      end
    end
    if (!finished) begin
      checkOutput({tag, " timeout"}, budget, 0);
    end else if (rstAfterRow < 0) begin
      @(negedge clk);
      start = 1'b0;
      checkOutput({tag, " done one cycle"}, done, 0);
      checkOutput({tag, " idle after done"}, busy, 0);
      checkOutput({tag, " count holds"}, active_count, expCount);
      @(negedge clk);
      checkOutput({tag, " no restart"}, busy, 0);
      checkOutput({tag, " count still holds"}, active_count, expCount);
    end
  endtask

  // Directed sequence: reset state first, then the scan scenarios in order.
  initial begin
    rst              = 1'b1;
    start            = 1'b1;
    row_ready        = 1'b1;
    central_in       = 24'hABCDEF;
    radius_square_in = 24'h123456;
    mode_in          = 2'd3;
    expC             = '0;
    expR             = '0;
    expM             = '0;
`ifdef SUBSET_SCAN_ABORT_EN
    abort            = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset row_valid", row_valid, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset count", active_count, 0);
    checkOutput("reset pos_x", pos_x, 0);
    checkOutput("reset pos_y", pos_y, 0);
    checkOutput("reset row_y", row_y, 0);
    checkOutput("reset row_mask", row_mask, 0);
    checkOutput("reset central", central, 0);
    checkOutput("reset radius", radius_square, 0);
    checkOutput("reset mode", mode, 0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checkOutput("idle after reset", busy, 0);

    $display("[TB] mode 0 single circle");
    applyStimulus(packC(4'd0, 4'd0, 4'd0, 4'd0), packR(8'd4, 8'd0), 2'd0);
    pushRows(16'h0007, 16'h0003, 16'h0001);
    runScan("t1", 0, 1'b0, 1'b0, -1, 273, 6);

    $display("[TB] mode 1 disjoint intersection");
    applyStimulus(packC(4'd0, 4'd0, 4'd15, 4'd15), packR(8'd4, 8'd4), 2'd1);
    pushRows(16'h0000, 16'h0000, 16'h0000);
    runScan("t2", 0, 1'b0, 1'b0, -1, 273, 0);

    $display("[TB] mode 2 difference");
    applyStimulus(packC(4'd0, 4'd0, 4'd1, 4'd0), packR(8'd1, 8'd0), 2'd2);
    pushRows(16'h0001, 16'h0001, 16'h0000);
    runScan("t3", 0, 1'b0, 1'b0, -1, 273, 2);

    $display("[TB] backpressure");
    applyStimulus(packC(4'd0, 4'd0, 4'd0, 4'd0), packR(8'd4, 8'd0), 2'd0);
    pushRows(16'h0007, 16'h0003, 16'h0001);
    runScan("t4", 5, 1'b0, 1'b0, -1, 353, 6);

    $display("[TB] start held and config churn");
    applyStimulus(packC(4'd0, 4'd0, 4'd0, 4'd0), packR(8'd4, 8'd0), 2'd0);
    pushRows(16'h0007, 16'h0003, 16'h0001);
    runScan("t5", 0, 1'b1, 1'b1, -1, 273, 6);

    $display("[TB] reset mid-scan then rerun");
    applyStimulus(packC(4'd0, 4'd0, 4'd0, 4'd0), packR(8'd4, 8'd0), 2'd0);
    pushRows(16'h0007, 16'h0003, 16'h0001);
    runScan("t6 rst", 0, 1'b0, 1'b0, 3, 0, 0);
    pushRows(16'h0007, 16'h0003, 16'h0001);
    runScan("t6 rerun", 0, 1'b0, 1'b0, -1, 273, 6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
